// File: rtl/dither_sequencer.sv
// Floyd-Steinberg dithering sequencer driving a single-port frame-buffer RAM.
// Pixels are walked in raster order: quantise the current pixel, then spread
// the error to the E, SW, S, SE neighbours that lie inside the frame.
module dither_sequencer #(
  parameter int unsigned IMAGEX   = 64,
  parameter int unsigned IMAGEY   = 64,
  parameter int unsigned RGB_SIZE = 8,
  parameter int unsigned ADDR_W   = $clog2(IMAGEX * IMAGEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RGB_SIZE-1:0] cfg_threshold,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  output logic [RGB_SIZE-1:0] mem_wdata,
  input  logic [RGB_SIZE-1:0] mem_rdata
);

  localparam int unsigned XW     = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int unsigned YW     = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam int unsigned ERR_W  = RGB_SIZE + 1;
  localparam int unsigned PROD_W = ERR_W + 4;
  localparam int unsigned SUM_W  = RGB_SIZE + 2;

  typedef enum logic [3:0] {
    IDLE, RD_CUR, WR_CUR, RD_E, WR_E, RD_SW, WR_SW,
    RD_S, WR_S, RD_SE, WR_SE, ADV, DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [XW-1:0]             x;
  logic [YW-1:0]             y;
  logic signed [ERR_W-1:0]   err;
  logic [RGB_SIZE-1:0]       thr;
  logic                      start_q;

  logic                      start_go;
  logic                      x_first, x_last, y_last, last_px;
  logic                      v_e, v_sw, v_s, v_se;
  state_t                    after_cur, after_e, after_sw, after_s;
  logic [ADDR_W-1:0]         cur_addr, addr_e, addr_sw, addr_s, addr_se;
  logic [RGB_SIZE-1:0]       quant_c;
  logic signed [ERR_W-1:0]   err_nxt_c;
  logic signed [PROD_W-1:0]  weight_c, prod_c, shift_c;
  logic signed [SUM_W-1:0]   sum_c;
  logic [RGB_SIZE-1:0]       nb_data_c;

  // Only a rising start seen in IDLE launches a pass; a held start does not retrigger.
  assign start_go = start && !start_q;

  // Position flags, neighbour validity and neighbour addresses.
  assign x_first  = (x == '0);
  assign x_last   = (x == XW'(IMAGEX - 1));
  assign y_last   = (y == YW'(IMAGEY - 1));
  assign last_px  = x_last && y_last;
  assign v_e      = !x_last;
  assign v_sw     = !y_last && !x_first;
  assign v_s      = !y_last;
  assign v_se     = !y_last && !x_last;
  assign cur_addr = ADDR_W'({y, x});
  assign addr_e   = cur_addr + ADDR_W'(1);
  assign addr_sw  = cur_addr + ADDR_W'(IMAGEX - 1);
  assign addr_s   = cur_addr + ADDR_W'(IMAGEX);
  assign addr_se  = cur_addr + ADDR_W'(IMAGEX + 1);

  // Skip chain: each point jumps to the next in-bounds neighbour, else ADV.
  assign after_s   = v_se ? RD_SE : ADV;
  assign after_sw  = v_s  ? RD_S  : after_s;
  assign after_e   = v_sw ? RD_SW : after_sw;
  assign after_cur = v_e  ? RD_E  : after_e;

  // Quantisation of the current pixel and its signed error.
  assign quant_c   = (mem_rdata >= thr) ? '1 : '0;
  assign err_nxt_c = $signed({1'b0, mem_rdata}) - $signed({1'b0, quant_c});

  // Weighted error diffusion into a neighbour, saturated to the pixel range.
  always_comb begin
    weight_c = '0;
    case (state)
      WR_E:    weight_c = PROD_W'(7);
      WR_SW:   weight_c = PROD_W'(3);
      WR_S:    weight_c = PROD_W'(5);
      WR_SE:   weight_c = PROD_W'(1);
      default: weight_c = '0;
    endcase
    prod_c  = PROD_W'(err) * weight_c;
    shift_c = prod_c >>> 4;
    sum_c   = SUM_W'(shift_c) + $signed({2'b00, mem_rdata});
    if (sum_c[SUM_W-1])      nb_data_c = '0;
    else if (sum_c[SUM_W-2]) nb_data_c = '1;
    else                     nb_data_c = sum_c[RGB_SIZE-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and RAM/handshake decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:   if (start_go) state_nxt = RD_CUR;
      RD_CUR: begin busy = 1'b1; mem_rd_en = 1'b1; mem_addr = cur_addr; state_nxt = WR_CUR; end
      WR_CUR: begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = cur_addr;
        mem_wdata = quant_c; state_nxt = after_cur;
      end
      RD_E:   begin busy = 1'b1; mem_rd_en = 1'b1; mem_addr = addr_e; state_nxt = WR_E; end
      WR_E:   begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = addr_e;
        mem_wdata = nb_data_c; state_nxt = after_e;
      end
      RD_SW:  begin busy = 1'b1; mem_rd_en = 1'b1; mem_addr = addr_sw; state_nxt = WR_SW; end
      WR_SW:  begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = addr_sw;
        mem_wdata = nb_data_c; state_nxt = after_sw;
      end
      RD_S:   begin busy = 1'b1; mem_rd_en = 1'b1; mem_addr = addr_s; state_nxt = WR_S; end
      WR_S:   begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = addr_s;
        mem_wdata = nb_data_c; state_nxt = after_s;
      end
      RD_SE:  begin busy = 1'b1; mem_rd_en = 1'b1; mem_addr = addr_se; state_nxt = WR_SE; end
      WR_SE:  begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = addr_se;
        mem_wdata = nb_data_c; state_nxt = ADV;
      end
      ADV:    begin busy = 1'b1; state_nxt = last_px ? DONE : RD_CUR; end
      DONE:   begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel position, latched threshold, carried error and start edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      err     <= '0;
      thr     <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      if (state == IDLE && start_go) begin
        thr <= cfg_threshold;
        x   <= '0;
        y   <= '0;
      end
      if (state == WR_CUR) err <= err_nxt_c;
      if (state == ADV && !last_px) begin
        if (x_last) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

endmodule

// File: doc/dither_sequencer.md
Name: dither_sequencer

Overview:
- Controller that runs Floyd-Steinberg dithering over an 8-bit greyscale frame held in an external single-port frame-buffer RAM.
- Walks pixels in raster order. For each pixel it quantises to 0/255 against a programmable threshold, writes the result back, then read-modify-writes the valid E/SW/S/SE neighbours with the weighted error.
- Sits between the host-side start/done control and the frame-buffer RAM. It owns the RAM port for the whole pass.

Parameters:
- IMAGEX, 64, image width in pixels; power of 2, ≥2
- IMAGEY, 64, image height in pixels; power of 2, ≥2
- RGB_SIZE, 8, pixel width in bits
- ADDR_W, $clog2(IMAGEX*IMAGEY), RAM address width

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a pass; ignored unless in IDLE
- cfg_threshold  input  RGB_SIZE  quantisation threshold; sampled on accepted start
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse at end of pass
- mem_addr  output  ADDR_W  RAM address; addr = y*IMAGEX + x
- mem_rd_en  output  1  RAM read strobe
- mem_wr_en  output  1  RAM write strobe
- mem_wdata  output  RGB_SIZE  RAM write data
- mem_rdata  input  RGB_SIZE  RAM read data; valid exactly 1 cycle after mem_rd_en

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state←IDLE; x, y, err, thr←0.
  - busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - Reset mid-pass aborts immediately. No RAM strobe is asserted in any cycle where state is IDLE after reset. Partially dithered RAM contents are left as-is.
- States: IDLE, RD_CUR, WR_CUR, RD_E, WR_E, RD_SW, WR_SW, RD_S, WR_S, RD_SE, WR_SE, ADV, DONE.
- IDLE → RD_CUR on start. Latch thr←cfg_threshold; x=y=0.
- RD_x states:
  - mem_rd_en=1, mem_addr = target address; next state is the matching WR_x.
- WR_CUR:
  - old = mem_rdata; new = (old ≥ thr) ? 255 : 0.
  - mem_wr_en=1, mem_wdata=new, same address.
  - err ← old − new, stored as signed 9-bit.
- WR_n (neighbour n, weight w: E=7, SW=3, S=5, SE=1):
  - mem_wdata = clamp(mem_rdata + ((err*w) >>> 4), 0, 255), same address, mem_wr_en=1.
  - Product in signed 13 bits; shift is arithmetic (floor toward −∞).
  - Sum in signed 10 bits before saturation.
  - mem_wdata is combinational from mem_rdata in this state.
- Neighbour order is fixed: E, SW, S, SE. A neighbour that is out of bounds is skipped entirely (no read, no write); the FSM jumps to the next valid RD_ state, or to ADV.
  - E valid iff x≠IMAGEX−1.
  - SW valid iff y≠IMAGEY−1 and x≠0.
  - S valid iff y≠IMAGEY−1.
  - SE valid iff y≠IMAGEY−1 and x≠IMAGEX−1.
- ADV (1 cycle, no strobes):
  - If last pixel (x=IMAGEX−1, y=IMAGEY−1) → DONE.
  - Otherwise increment x, wrapping to 0 with y+1, then → RD_CUR.
- DONE: done=1, busy=0 for exactly one cycle, then → IDLE. A start seen in DONE is ignored.
- busy=1 in every state except IDLE and DONE.
- Never mem_rd_en and mem_wr_en in the same cycle. Exactly one strobe is high in every RD/WR state.
- Timing: 2 cycles per RAM access plus 1 ADV cycle per pixel. An interior pixel takes 11 cycles.
- start while busy: no effect. cfg_threshold changes mid-pass: no effect.

Test Plan:
- 4x4 image, all RAM=0, thr=128, start:
  - 58 writes and 58 reads total.
  - busy high exactly 132 cycles; done pulses once.
  - Final RAM all 0.
- 4x4, all RAM=0x80, thr=128, single-step the first pixel:
  - addr0←255; err=−127.
  - addr1 (E) ←72, addr4 (S) ←88, addr5 (SE) ←120.
  - No access to any SW address.
- Saturation, 4x4 with RAM[0]=0x7F, RAM[1]=0xFF, thr=128:
  - addr0←0, err=+127; addr1 computes 255+55 and clamps to 255.
  - Companion case: RAM[0]=0xFF, RAM[1]=0x00 → err=0, addr1 stays 0.
- Boundaries, 4x4: trace the access sequence.
  - Pixel 3 (x=3,y=0): only SW(6) and S(7).
  - Pixels 12–15: no neighbour accesses except E; pixel 15 has none, then DONE.
- Reset mid-pass: assert rst during WR_S of pixel 5.
  - Next cycle busy=0, no strobes, done never pulses.
  - A new start restarts from addr0.
- Handshake: start held high across a whole pass plus a start pulse during DONE.
  - Exactly one pass per rising start in IDLE.
  - Threshold latched at start: changing cfg_threshold mid-pass does not alter results.
